mealy_frame_ctrl: RTL and testbench
===================================

Name: mealy_frame_ctrl

Overview:
Sequencer for the 2-bit-symbol Mealy recognizer (`a[1:0]` in, `y[1:0]` out).
- Accepts symbol frames from an upstream valid/ready stream.
- Clears the recognizer before each frame and feeds it one symbol per accepted beat.
- Collects its Mealy outputs and returns a per-frame result record over a second valid/ready handshake.
- Sits between the stimulus/packet source and the recognizer instance; it is the only driver of the recognizer's inputs.

Parameters:
MAX_LEN, 16, maximum symbols per frame before forced termination (≥2)
CNT_W, 8, width of hit counter and length counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
s_valid  in  1  upstream symbol valid
s_ready  out  1  upstream symbol ready
s_sym  in  2  upstream symbol
s_last  in  1  final symbol of frame
det_clr  out  1  recognizer clear, one-cycle pulse
det_en  out  1  recognizer advance enable; recognizer state updates only when 1
det_a  out  2  recognizer input a
det_y  in  2  recognizer Mealy output y (combinational from det_a and state)
r_valid  out  1  result valid
r_ready  in  1  result ready
r_hits  out  CNT_W  accepted beats with det_y != 2'b00
r_len  out  CNT_W  symbols fed to recognizer in this frame
r_last_y  out  2  det_y sampled on the final fed symbol
r_ovf  out  1  frame hit MAX_LEN without s_last
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state IDLE; hits=0, len=0, last_y=00, ovf=0; r_valid=0; det_clr=0; det_en=0; det_a=00; s_ready=0; busy=0.
- States: IDLE, CLR, RUN, DRAIN, RESP.
- IDLE:
  - s_ready=0.
  - If s_valid=1, go to CLR next cycle and zero hits/len/ovf/last_y.
- CLR:
  - det_clr=1 for exactly one cycle; s_ready=0; det_en=0.
  - Next state RUN.
- RUN:
  - s_ready=1.
  - Accept = s_valid & s_ready.
  - det_a = s_sym when accepting, else 00 (combinational); det_en = accept.
  - On accept: len += 1; hits += 1 if det_y != 00 (det_y sampled in the same cycle); last_y <= det_y.
  - hits saturates at 2^CNT_W−1. len never exceeds MAX_LEN.
  - Accept with s_last=1 → RESP.
  - Accept with s_last=0 and len+1 == MAX_LEN → ovf<=1, DRAIN.
  - If both conditions hold (s_last=1 on beat MAX_LEN): → RESP, ovf=0.
  - No accept → hold; recognizer not advanced (det_en=0).
- DRAIN:
  - s_ready=1; det_en=0; det_a=00.
  - Beats are discarded and leave hits, len and last_y unchanged.
  - Accept with s_last=1 → RESP.
- RESP:
  - r_valid=1; r_* hold registered values stable; s_ready=0.
  - On r_valid & r_ready → IDLE next cycle, r_valid=0.
- Latency:
  - First accepted symbol at earliest cycle 2 after s_valid rises in IDLE (IDLE→CLR→RUN).
  - r_valid asserts the cycle after the last beat is accepted.
- Back-to-back frames: RESP→IDLE→CLR; at least 3 idle-input cycles between frames.
- Frame with single symbol (s_last on first beat): len=1, RESP normally.
- Reset asserted mid-frame: immediate return to reset values. Any upstream frame in flight is abandoned and no result is produced. The recognizer is cleared by the next CLR.
- det_clr and det_en are never both 1.

Test Plan:
All scenarios use a bench recognizer stub with y = 01 when a == 11, else 00.
- Reset then frame 11,00,11,10,01 (last on 01), r_ready=1 → one det_clr pulse before first det_en; r_hits=2, r_len=5, r_last_y=00, r_ovf=0; r_valid one cycle after last accept.
- Frame 11,01,10,11 with s_valid gaps of 2 cycles between beats → det_en=1 only on 4 accept cycles; r_hits=2, r_len=4, r_last_y=01.
- MAX_LEN=16: 20 symbols of 11, last on 20th → r_len=16, r_hits=16, r_ovf=1; beats 17–20 accepted with det_en=0; single r_valid after beat 20.
- Exactly 16 symbols, last on 16th → r_ovf=0, r_len=16.
- r_ready held 0 for 5 cycles in RESP → r_valid and r_* stable; s_ready=0; next frame not accepted until handshake.
- rst low for 1 cycle after 3rd beat of a frame → all outputs reset values immediately. Following frame 10,11 (last) → r_hits=1, r_len=2 with a fresh det_clr.

Source files
------------

// File: rtl/mealy_frame_ctrl.sv
// mealy_frame_ctrl
//   Takes symbol frames from an upstream valid/ready stream. Before each frame
//   it clears the 2-bit Mealy recognizer, then feeds it one symbol per accepted
//   beat. It collects the recognizer outputs and returns one result record per
//   frame over a second valid/ready handshake.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for s_valid; result counters are zeroed on exit
//   CLR   | one-cycle recognizer clear pulse
//   RUN   | feeding accepted symbols to the recognizer
//   DRAIN | frame hit MAX_LEN without s_last; discard beats up to s_last
//   RESP  | presenting the result record until r_ready
//
// Ports
//   clk, rst                 clock (rising edge), async active-low reset
//   s_valid/s_ready/s_sym/s_last   upstream symbol stream
//   det_clr/det_en/det_a/det_y     recognizer interface (det_y is combinational)
//   r_valid/r_ready          result handshake
//   r_hits, r_len, r_last_y, r_ovf result record
//   busy                     controller is not in IDLE
module mealy_frame_ctrl #(
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_sym,
  input  logic             s_last,
  output logic             det_clr,
  output logic             det_en,
  output logic [1:0]       det_a,
  input  logic [1:0]       det_y,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [CNT_W-1:0] r_hits,
  output logic [CNT_W-1:0] r_len,
  output logic [1:0]       r_last_y,
  output logic             r_ovf,
  output logic             busy
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, RESP} state_t;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HITS_MAX = '1;
  localparam logic [CNT_W-1:0] LEN_LAST = CNT_W'(MAX_LEN - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] hits, len;
  logic [1:0]       last_y;
  logic             ovf;
  logic             accept;
  logic             len_full;

  // the beat being accepted now is the MAX_LEN-th symbol of the frame
  assign len_full = (len == LEN_LAST);
  assign accept   = s_valid & s_ready;

  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    det_clr   = 1'b0;
    det_en    = 1'b0;
    det_a     = 2'b00;
    r_valid   = 1'b0;
    case (state)
      IDLE: begin
        if (s_valid) state_nxt = CLR;
      end
      CLR: begin
        det_clr   = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          det_en = 1'b1;
          det_a  = s_sym;
          if (s_last)        state_nxt = RESP;
          else if (len_full) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        s_ready = 1'b1;
        if (s_valid && s_last) state_nxt = RESP;
      end
      RESP: begin
        r_valid = 1'b1;
        if (r_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      hits   <= '0;
      len    <= '0;
      last_y <= 2'b00;
      ovf    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (s_valid) begin
            hits   <= '0;
            len    <= '0;
            last_y <= 2'b00;
            ovf    <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            len    <= len + ONE;
            last_y <= det_y;
            if (det_y != 2'b00 && hits != HITS_MAX) hits <= hits + ONE;
            // s_last on the MAX_LEN-th beat is a normal end, not an overflow
            if (!s_last && len_full) ovf <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r_hits   = hits;
  assign r_len    = len;
  assign r_last_y = last_y;
  assign r_ovf    = ovf;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mealy_frame_ctrl.sv
module tb_mealy_frame_ctrl;
  localparam int MAX_LEN = 16;
  localparam int CNT_W   = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, s_last;
  logic [1:0]       s_sym;
  logic             det_clr, det_en;
  logic [1:0]       det_a, det_y;
  logic             r_valid, r_ready;
  logic [CNT_W-1:0] r_hits, r_len;
  logic [1:0]       r_last_y;
  logic             r_ovf, busy;

  mealy_frame_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym), .s_last(s_last),
    .det_clr(det_clr), .det_en(det_en), .det_a(det_a), .det_y(det_y),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_hits(r_hits), .r_len(r_len), .r_last_y(r_last_y), .r_ovf(r_ovf),
    .busy(busy)
  );

  // recognizer stub: y = 01 when a == 11
  assign det_y = (det_a == 2'b11) ? 2'b01 : 2'b00;

  always #5 clk = ~clk;

  typedef struct {
    int hits;
    int len;
    int last_y;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rr_hold = 0;
  bit   rr_rand = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference: first min(n, MAX_LEN) symbols are fed; a hit is a fed 11 symbol
  function automatic exp_t ref_model(input logic [1:0] syms[$]);
    exp_t e;
    int n = syms.size();
    int fed = (n < MAX_LEN) ? n : MAX_LEN;
    e.hits = 0;
    for (int i = 0; i < fed; i++) if (syms[i] == 2'b11) e.hits++;
    if (e.hits > 255) e.hits = 255;
    e.len    = fed;
    e.last_y = (syms[fed-1] == 2'b11) ? 1 : 0;
    e.ovf    = (n > MAX_LEN) ? 1 : 0;
    return e;
  endfunction

  // called at posedge+#1; returns at posedge+#1 after the beat is taken
  task automatic send_beat(input logic [1:0] sym, input logic last);
    int t = 0;
    s_valid = 1'b1; s_sym = sym; s_last = last;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 300) begin
        n_vec++; n_err++;
        $display("FAIL beat_timeout: s_ready stayed 0, required 1");
        break;
      end
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_sym = 2'b00; s_last = 1'b0;
  endtask

  task automatic send_frame(input logic [1:0] syms[$], input int gap);
    exp_q.push_back(ref_model(syms));
    for (int i = 0; i < syms.size(); i++) begin
      if (i > 0) repeat (gap) begin @(posedge clk); #1; end
      send_beat(syms[i], i == syms.size() - 1);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy || exp_q.size() != 0) begin
      @(posedge clk); #1;
      t++;
      if (t > 500) begin
        n_vec++; n_err++;
        $display("FAIL idle_timeout: busy=%0d pending=%0d, required 0 0", busy, exp_q.size());
        break;
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rr_hold > 0) begin
      r_ready = 1'b0;
      rr_hold--;
    end else begin
      r_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: protocol checks every cycle, result check on each handshake
  int   en_cnt = 0, clr_cnt = 0;
  bit   pend_last = 0, prev_rv = 0;
  exp_t mon_e;
  logic [CNT_W-1:0] h_hits, h_len;
  logic [1:0]       h_last_y;
  logic             h_ovf;

  always @(negedge clk) begin
    if (!rst) begin
      en_cnt = 0; clr_cnt = 0; pend_last = 0; prev_rv = 0;
    end else begin
      chk("clr_en_exclusive", int'(det_clr & det_en), 0);
      chk("det_a", int'(det_a), det_en ? int'(s_sym) : 0);
      if (det_clr) clr_cnt++;
      if (det_en) begin
        if (en_cnt == 0) chk("clr_before_en", clr_cnt, 1);
        en_cnt++;
      end
      if (pend_last) begin
        chk("rvalid_latency", int'(r_valid), 1);
        pend_last = 0;
      end
      if (s_valid && s_ready && s_last) pend_last = 1;
      if (r_valid) begin
        chk("resp_s_ready", int'(s_ready), 0);
        if (prev_rv) begin
          chk("hold_hits", int'(r_hits), int'(h_hits));
          chk("hold_len", int'(r_len), int'(h_len));
          chk("hold_last_y", int'(r_last_y), int'(h_last_y));
          chk("hold_ovf", int'(r_ovf), int'(h_ovf));
        end
      end
      if (r_valid && r_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_result: result with empty scoreboard");
        end else begin
          mon_e = exp_q.pop_front();
          chk("r_hits", int'(r_hits), mon_e.hits);
          chk("r_len", int'(r_len), mon_e.len);
          chk("r_last_y", int'(r_last_y), mon_e.last_y);
          chk("r_ovf", int'(r_ovf), mon_e.ovf);
          chk("det_en_count", en_cnt, mon_e.len);
          chk("det_clr_count", clr_cnt, 1);
        end
        en_cnt = 0; clr_cnt = 0; prev_rv = 0;
      end else begin
        prev_rv = r_valid;
        h_hits = r_hits; h_len = r_len; h_last_y = r_last_y; h_ovf = r_ovf;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_r_valid"}, int'(r_valid), 0);
    chk({tag, "_s_ready"}, int'(s_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_det_clr"}, int'(det_clr), 0);
    chk({tag, "_det_en"}, int'(det_en), 0);
    chk({tag, "_det_a"}, int'(det_a), 0);
    chk({tag, "_r_hits"}, int'(r_hits), 0);
    chk({tag, "_r_len"}, int'(r_len), 0);
    chk({tag, "_r_last_y"}, int'(r_last_y), 0);
    chk({tag, "_r_ovf"}, int'(r_ovf), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] f[$];
    rst = 1'b0; s_valid = 1'b0; s_sym = 2'b00; s_last = 1'b0; r_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    f = '{2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
    send_frame(f, 0);
    wait_idle();

    f = '{2'b11, 2'b01, 2'b10, 2'b11};
    send_frame(f, 2);
    wait_idle();

    f = {};
    for (int i = 0; i < 20; i++) f.push_back(2'b11);
    send_frame(f, 0);
    wait_idle();

    f = {};
    for (int i = 0; i < 16; i++) f.push_back(2'b11);
    send_frame(f, 0);
    wait_idle();

    // result backpressure: r_ready low for 5 cycles, next frame waiting
    f = '{2'b01, 2'b11};
    send_frame(f, 0);
    rr_hold = 5;
    s_valid = 1'b1; s_sym = 2'b11; s_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_r_valid", int'(r_valid), 1);
      chk("bp_det_en", int'(det_en), 0);
    end
    s_valid = 1'b0; s_sym = 2'b00; s_last = 1'b0;
    wait_idle();

    // reset mid-frame: three beats then abandon
    send_beat(2'b11, 1'b0);
    send_beat(2'b01, 1'b0);
    send_beat(2'b11, 1'b0);
    rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b1;
    f = '{2'b10, 2'b11};
    send_frame(f, 0);
    wait_idle();

    rr_rand = 1;
    for (int k = 0; k < 30; k++) begin
      int n = $urandom_range(1, 22);
      f = {};
      for (int i = 0; i < n; i++) f.push_back(2'($urandom_range(0, 3)));
      send_frame(f, $urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    rr_rand = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
